// File: rtl/usb_bit_stuff_tx.sv
// ----------------------------------------------------------------------------
// usb_bit_stuff_tx
//
// Full-speed USB transmit back end. It takes a raw, LSB-first bit stream from
// upstream (SYNC included), inserts a 0 after every STUFF_LEN consecutive raw
// 1s, NRZI-encodes the result onto D+/D-, and closes the packet with an EOP
// (two SE0 bit times followed by one J bit time).
//
// Parameters
//   STUFF_LEN  number of consecutive raw 1s after which a stuff bit is inserted
//
// Ports
//   clk12      in   12 MHz bit clock, one line bit per cycle
//   RST        in   synchronous, active-high reset
//   txStart    in   single-cycle packet request, only looked at in IDLE
//   dataIn     in   next raw bit from upstream
//   dataValid  in   dataIn holds a valid bit
//   dataReady  out  combinational; high in the cycle dataIn is consumed
//   eopReq     in   upstream has no more data, only looked at in SEND
//   dp         out  registered D+ level
//   dn         out  registered D- level
//   outEn      out  registered transceiver output enable
//   eopDone    out  registered one-cycle pulse in the first IDLE cycle after EOP
//   underrun   out  registered sticky flag: SEND starved without eopReq
//
// Every bit decided in cycle N appears on dp/dn in cycle N+1. The line
// outputs are therefore registered from the next-state values, so the SE0/J
// pattern of the EOP lines up with the SE0_1/SE0_2/EOP_J states themselves.
// ----------------------------------------------------------------------------

module usb_bit_stuff_tx #(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic clk12,
    input  logic RST,
    input  logic txStart,
    input  logic dataIn,
    input  logic dataValid,
    output logic dataReady,
    input  logic eopReq,
    output logic dp,
    output logic dn,
    output logic outEn,
    output logic eopDone,
    output logic underrun
);

    // Counter must be able to hold the value STUFF_LEN itself.
    localparam int unsigned CntW = (STUFF_LEN < 1) ? 1 : $clog2(STUFF_LEN + 1);
    localparam logic [CntW-1:0] StuffMax = CntW'(STUFF_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StSe01,
        StSe02,
        StEopJ
    } state_e;

    state_e          state_q, state_d;

    // Datapath state: run length of raw 1s and the current NRZI level (1 = J).
    logic [CntW-1:0] ones_q, ones_d;
    logic            level_q, level_d;

    // Registered outputs.
    logic            dp_q, dp_d;
    logic            dn_q, dn_d;
    logic            out_en_q, out_en_d;
    logic            eop_done_q, eop_done_d;
    logic            underrun_q, underrun_d;

    // SEND-state decisions in priority order. A pending stuff bit beats
    // everything, including the end of the packet.
    logic in_send;
    logic stuff_now;
    logic take_bit;
    logic end_req;
    logic starve;

    always_comb begin
        in_send   = (state_q == StSend);
        stuff_now = in_send && (ones_q == StuffMax);
        take_bit  = in_send && !stuff_now && dataValid;
        end_req   = in_send && !stuff_now && !dataValid && eopReq;
        starve    = in_send && !stuff_now && !dataValid && !eopReq;
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk12) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (txStart) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (end_req || starve) begin
                    state_d = StSe01;
                end
            end
            StSe01:  state_d = StSe02;
            StSe02:  state_d = StEopJ;
            StEopJ:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs and datapath next state
    // ------------------------------------------------------------------------
    always_comb begin
        dataReady  = 1'b0;
        ones_d     = ones_q;
        level_d    = level_q;
        underrun_d = underrun_q;

        unique case (state_q)
            StIdle: begin
                ones_d  = '0;
                level_d = 1'b1;
                if (txStart) begin
                    underrun_d = 1'b0;
                end
            end
            StSend: begin
                if (stuff_now) begin
                    // Stuff bit is a 0: toggle the line and restart the run.
                    level_d = ~level_q;
                    ones_d  = '0;
                end else if (take_bit) begin
                    dataReady = 1'b1;
                    if (dataIn) begin
                        // take_bit implies ones_q < StuffMax, so no overflow.
                        ones_d = ones_q + CntW'(1);
                    end else begin
                        level_d = ~level_q;
                        ones_d  = '0;
                    end
                end else if (starve) begin
                    underrun_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Line level follows the state the FSM is entering.
        unique case (state_d)
            StSend: begin
                dp_d = level_d;
                dn_d = ~level_d;
            end
            StSe01, StSe02: begin
                dp_d = 1'b0;
                dn_d = 1'b0;
            end
            default: begin
                dp_d = 1'b1;
                dn_d = 1'b0;
            end
        endcase

        out_en_d   = (state_d != StIdle);
        eop_done_d = (state_q == StEopJ);
    end

    // ------------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk12) begin
        if (RST) begin
            ones_q     <= '0;
            level_q    <= 1'b1;
            dp_q       <= 1'b1;
            dn_q       <= 1'b0;
            out_en_q   <= 1'b0;
            eop_done_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            ones_q     <= ones_d;
            level_q    <= level_d;
            dp_q       <= dp_d;
            dn_q       <= dn_d;
            out_en_q   <= out_en_d;
            eop_done_q <= eop_done_d;
            underrun_q <= underrun_d;
        end
    end

    assign dp       = dp_q;
    assign dn       = dn_q;
    assign outEn    = out_en_q;
    assign eopDone  = eop_done_q;
    assign underrun = underrun_q;

endmodule
